// File: rtl/img_loader_pkg.sv
// Shared definitions for the image loader and the image buffer:
// frame geometry, command bytes and the loader state encoding.
package img_loader_pkg;

  localparam int IMG_TOTAL_BITS = 904;
  localparam int FRAME_BYTES    = IMG_TOTAL_BITS / 8;
  localparam int CNT_W          = $clog2(FRAME_BYTES + 1);

  localparam logic [7:0] CMD_START = 8'hA5;
  localparam logic [7:0] CMD_CLEAR = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECV,
    WAIT_FULL,
    INFER
  } loader_state_t;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer. Counts enabled cycles since the last clear and
// flags the cycle in which the idle time reaches LIMIT. Only built when
// IMG_LOADER_TIMEOUT_EN is defined.
module rx_timeout_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Idle counter; saturates so a stuck enable cannot wrap it.
  always_ff @(posedge clk) begin
    if (rst || clear)                      cnt <= '0;
    else if (enable && cnt != W'(LIMIT))   cnt <= cnt + 1'b1;
  end

  assign expired = enable && !clear && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/image_loader_ctrl.sv
// Image loader control: decodes the start/clear command bytes from the
// serial receiver, writes one frame of payload into the image buffer,
// then hands the frame to inference and holds off until it is done.
// Optional inter-byte timeout in RECV: define IMG_LOADER_TIMEOUT_EN.
module image_loader_ctrl
  import img_loader_pkg::*;
#(
  parameter int FULL_WAIT_MAX = 4
`ifdef IMG_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             buf_full,
  input  logic             infer_done,
  output logic [7:0]       buf_data,
  output logic             buf_we,
  output logic             buf_clear,
  output logic             infer_start,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] bytes_rcvd
);

  localparam int WW = $clog2(FULL_WAIT_MAX + 1);

  loader_state_t state, ret;
  logic [WW-1:0] wait_cnt;
  // A byte arriving in the CLEAR cycle is parked here so its write lands
  // the cycle after buf_clear instead of colliding with it.
  logic          pend_vld;
  logic [7:0]    pend_data;
  logic          timeout_hit;

`ifdef IMG_LOADER_TIMEOUT_EN
  rx_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid || state != RECV),
    .enable  (state == RECV),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Loader FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ret         <= IDLE;
      wait_cnt    <= '0;
      pend_vld    <= 1'b0;
      pend_data   <= '0;
      buf_data    <= '0;
      buf_we      <= 1'b0;
      buf_clear   <= 1'b0;
      infer_start <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
      bytes_rcvd  <= '0;
    end else begin
      buf_we      <= 1'b0;
      buf_clear   <= 1'b0;
      infer_start <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && rx_byte == CMD_START) begin
            state <= CLEAR;
            ret   <= RECV;
            busy  <= 1'b1;
          end else if (rx_valid && rx_byte == CMD_CLEAR) begin
            state <= CLEAR;
            ret   <= IDLE;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          buf_clear  <= 1'b1;
          bytes_rcvd <= '0;
          state      <= ret;
          busy       <= (ret != IDLE);
          if (rx_valid && ret == RECV) begin
            pend_vld  <= 1'b1;
            pend_data <= rx_byte;
          end
        end
        RECV: begin
          if (timeout_hit) begin
            frame_err <= 1'b1;
            buf_clear <= 1'b1;
            pend_vld  <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (pend_vld || rx_valid) begin
            buf_we     <= 1'b1;
            buf_data   <= pend_vld ? pend_data : rx_byte;
            bytes_rcvd <= bytes_rcvd + 1'b1;
            // A new byte behind a parked one stays parked for next cycle.
            pend_vld   <= pend_vld && rx_valid;
            pend_data  <= rx_byte;
            if (bytes_rcvd == CNT_W'(FRAME_BYTES - 1)) begin
              state    <= WAIT_FULL;
              wait_cnt <= '0;
              pend_vld <= 1'b0;
            end
          end
        end
        WAIT_FULL: begin
          if (rx_valid) frame_err <= 1'b1;
          if (buf_full) begin
            infer_start <= 1'b1;
            state       <= INFER;
          end else if (wait_cnt == WW'(FULL_WAIT_MAX - 1)) begin
            frame_err <= 1'b1;
            buf_clear <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        INFER: begin
          if (rx_valid) frame_err <= 1'b1;
          if (infer_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_loader_ctrl.sv
// Directed bench for image_loader_ctrl: reset, clear command, full frame,
// overrun during inference, missing buffer-full, reset mid-frame and a
// byte arriving in the clear cycle.
module tb_image_loader_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       buf_full = 1'b0;
  logic       infer_done = 1'b0;
  logic [7:0] buf_data;
  logic       buf_we, buf_clear, infer_start, busy, frame_err;
  logic [6:0] bytes_rcvd;

  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0, clr_cnt = 0, st_cnt = 0, err_cnt = 0, excl_bad = 0;

  image_loader_ctrl dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .buf_full(buf_full), .infer_done(infer_done), .buf_data(buf_data),
    .buf_we(buf_we), .buf_clear(buf_clear), .infer_start(infer_start),
    .busy(busy), .frame_err(frame_err), .bytes_rcvd(bytes_rcvd)
  );

  always #5 clk = ~clk;

  // Pulse counters and strobe exclusivity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (buf_we)      we_cnt++;
    if (buf_clear)   clr_cnt++;
    if (infer_start) st_cnt++;
    if (frame_err)   err_cnt++;
    if (int'(buf_we) + int'(buf_clear) + int'(infer_start) > 1) excl_bad++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_start();
    rx_valid = 1'b1; rx_byte = 8'hA5; step();
    rx_valid = 1'b0; step();
  endtask

  task automatic send_payload(input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1; rx_byte = 8'(i); step();
      rx_valid = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    vectors++;
    if ({buf_data, buf_we, buf_clear, infer_start, busy, frame_err, bytes_rcvd} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h we=%b clr=%b st=%b busy=%b err=%b cnt=%0d want all 0",
               buf_data, buf_we, buf_clear, infer_start, busy, frame_err, bytes_rcvd);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_clear_cmd();
    int s_we, s_clr;
    s_we = we_cnt; s_clr = clr_cnt;
    rx_valid = 1'b1; rx_byte = 8'h5A; step();
    rx_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || buf_clear !== 1'b0) begin miscompares++; $display("FAIL clr_cycle: got busy=%b clr=%b want 1 0", busy, buf_clear); end
    step();
    vectors++; if (busy !== 1'b0 || buf_clear !== 1'b1) begin miscompares++; $display("FAIL clr_pulse: got busy=%b clr=%b want 0 1", busy, buf_clear); end
    step();
    vectors++; if (busy !== 1'b0 || buf_clear !== 1'b0) begin miscompares++; $display("FAIL clr_after: got busy=%b clr=%b want 0 0", busy, buf_clear); end
    vectors++; if (clr_cnt - s_clr !== 1 || we_cnt - s_we !== 0) begin miscompares++; $display("FAIL clr_counts: got clr=%0d we=%0d want 1 0", clr_cnt - s_clr, we_cnt - s_we); end
    rx_valid = 1'b1; rx_byte = 8'h33; step();
    rx_valid = 1'b0; step();
    vectors++; if (busy !== 1'b0 || buf_clear !== 1'b0) begin miscompares++; $display("FAIL idle_junk: got busy=%b clr=%b want 0 0", busy, buf_clear); end
  endtask

  task automatic test_full_frame();
    int s_we, s_st, bad;
    s_we = we_cnt; s_st = st_cnt; bad = 0;
    rx_valid = 1'b1; rx_byte = 8'hA5; step();
    rx_valid = 1'b0;
    vectors++; if (busy !== 1'b1 || buf_clear !== 1'b0) begin miscompares++; $display("FAIL ff_clear_cycle: got busy=%b clr=%b want 1 0", busy, buf_clear); end
    step();
    vectors++; if (buf_clear !== 1'b1 || bytes_rcvd !== 7'd0) begin miscompares++; $display("FAIL ff_clear_pulse: got clr=%b cnt=%0d want 1 0", buf_clear, bytes_rcvd); end
    for (int i = 0; i < 113; i++) begin
      rx_valid = 1'b1; rx_byte = 8'(i); step();
      rx_valid = 1'b0;
      vectors++;
      if (buf_we !== 1'b1 || buf_data !== 8'(i) || bytes_rcvd !== 7'(i + 1)) begin
        miscompares++; bad++;
        if (bad < 4) $display("FAIL ff_write%0d: got we=%b data=%h cnt=%0d want 1 %h %0d", i, buf_we, buf_data, bytes_rcvd, 8'(i), i + 1);
      end
      step();
    end
    // Buffer model: full rises two cycles after the final write strobe.
    step(); buf_full = 1'b1;
    vectors++; if (infer_start !== 1'b0) begin miscompares++; $display("FAIL ff_start_early: got %b want 0", infer_start); end
    step(); buf_full = 1'b0;
    vectors++; if (infer_start !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL ff_start: got st=%b busy=%b want 1 1", infer_start, busy); end
    step(); step(); step();
    vectors++; if (infer_start !== 1'b0 || busy !== 1'b1 || bytes_rcvd !== 7'd113) begin miscompares++; $display("FAIL ff_infer_hold: got st=%b busy=%b cnt=%0d want 0 1 113", infer_start, busy, bytes_rcvd); end
    vectors++; if (we_cnt - s_we !== 113 || st_cnt - s_st !== 1) begin miscompares++; $display("FAIL ff_counts: got we=%0d st=%0d want 113 1", we_cnt - s_we, st_cnt - s_st); end
    // Done and a start command in the same cycle: command is dropped.
    infer_done = 1'b1; rx_valid = 1'b1; rx_byte = 8'hA5; step();
    infer_done = 1'b0; rx_valid = 1'b0;
    vectors++; if (frame_err !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL ff_done_rx: got err=%b busy=%b want 1 0", frame_err, busy); end
    step();
    vectors++; if (busy !== 1'b0 || buf_clear !== 1'b0 || bytes_rcvd !== 7'd113) begin miscompares++; $display("FAIL ff_cmd_dropped: got busy=%b clr=%b cnt=%0d want 0 0 113", busy, buf_clear, bytes_rcvd); end
  endtask

  task automatic test_overrun();
    int s_we, s_err;
    send_start(); send_payload(113);
    step(); buf_full = 1'b1; step(); buf_full = 1'b0;
    s_we = we_cnt; s_err = err_cnt;
    for (int k = 0; k < 3; k++) begin
      rx_valid = 1'b1; rx_byte = 8'hA5; step();
      rx_valid = 1'b0;
      vectors++; if (frame_err !== 1'b1 || buf_we !== 1'b0) begin miscompares++; $display("FAIL ov_err%0d: got err=%b we=%b want 1 0", k, frame_err, buf_we); end
      step();
    end
    vectors++; if (err_cnt - s_err !== 3 || we_cnt - s_we !== 0 || busy !== 1'b1) begin miscompares++; $display("FAIL ov_counts: got err=%0d we=%0d busy=%b want 3 0 1", err_cnt - s_err, we_cnt - s_we, busy); end
    infer_done = 1'b1; step(); infer_done = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ov_done: got busy=%b want 0", busy); end
    rx_valid = 1'b1; rx_byte = 8'hA5; step(); rx_valid = 1'b0; step();
    vectors++; if (busy !== 1'b1 || buf_clear !== 1'b1 || bytes_rcvd !== 7'd0) begin miscompares++; $display("FAIL ov_restart: got busy=%b clr=%b cnt=%0d want 1 1 0", busy, buf_clear, bytes_rcvd); end
  endtask

  task automatic test_full_timeout();
    rst = 1'b1; step(); rst = 1'b0;
    send_start(); send_payload(113);
    step(); step();
    vectors++; if (frame_err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL to_early: got err=%b busy=%b want 0 1", frame_err, busy); end
    step();
    vectors++; if (frame_err !== 1'b1 || buf_clear !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL to_fire: got err=%b clr=%b busy=%b want 1 1 0", frame_err, buf_clear, busy); end
    step();
    vectors++; if (frame_err !== 1'b0 || buf_clear !== 1'b0 || infer_start !== 1'b0) begin miscompares++; $display("FAIL to_after: got err=%b clr=%b st=%b want 0 0 0", frame_err, buf_clear, infer_start); end
  endtask

  task automatic test_reset_mid();
    int s_we, s_clr;
    send_start(); send_payload(50);
    vectors++; if (bytes_rcvd !== 7'd50 || busy !== 1'b1) begin miscompares++; $display("FAIL rm_partial: got cnt=%0d busy=%b want 50 1", bytes_rcvd, busy); end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++;
    if ({buf_data, buf_we, buf_clear, infer_start, busy, frame_err, bytes_rcvd} !== 21'd0) begin
      miscompares++;
      $display("FAIL rm_outputs: got data=%h we=%b clr=%b busy=%b err=%b cnt=%0d want all 0",
               buf_data, buf_we, buf_clear, busy, frame_err, bytes_rcvd);
    end
    s_we = we_cnt; s_clr = clr_cnt;
    rx_valid = 1'b1; rx_byte = 8'h11; step(); rx_valid = 1'b0; step();
    rx_valid = 1'b1; rx_byte = 8'h22; step(); rx_valid = 1'b0; step();
    vectors++; if (we_cnt - s_we !== 0 || clr_cnt - s_clr !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL rm_idle: got we=%0d clr=%0d busy=%b want 0 0 0", we_cnt - s_we, clr_cnt - s_clr, busy); end
  endtask

  task automatic test_back_to_back();
    rx_valid = 1'b1; rx_byte = 8'hA5; step();
    rx_byte = 8'hFF; step();
    rx_valid = 1'b0;
    vectors++; if (buf_clear !== 1'b1 || buf_we !== 1'b0) begin miscompares++; $display("FAIL bb_clear: got clr=%b we=%b want 1 0", buf_clear, buf_we); end
    step();
    vectors++; if (buf_we !== 1'b1 || buf_data !== 8'hFF || bytes_rcvd !== 7'd1 || buf_clear !== 1'b0) begin miscompares++; $display("FAIL bb_write: got we=%b data=%h cnt=%0d clr=%b want 1 ff 1 0", buf_we, buf_data, bytes_rcvd, buf_clear); end
    step();
    vectors++; if (buf_we !== 1'b0 || bytes_rcvd !== 7'd1) begin miscompares++; $display("FAIL bb_after: got we=%b cnt=%0d want 0 1", buf_we, bytes_rcvd); end
  endtask

  initial begin
    test_reset();
    test_clear_cmd();
    test_full_frame();
    test_overrun();
    test_full_timeout();
    test_reset_mid();
    test_back_to_back();
    step();
    vectors++; if (excl_bad !== 0) begin miscompares++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", excl_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
